// File: rtl/strum_seq_pkg.sv
// Shared definitions for the strum sequencer.
//   state_t   : sequencer FSM states
//   cmd_t     : command word layout {mask, hold} at the default hold width
//   LINE_*    : bit positions of the instrument lines in mask/inst
package strum_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRESS = 3'd2,
    S_REST  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int unsigned CMD_HOLD_W = 8;

  typedef struct packed {
    logic [2:0]            mask;
    logic [CMD_HOLD_W-1:0] hold;
  } cmd_t;

  localparam int unsigned LINE_GREEN = 0;
  localparam int unsigned LINE_BLUE  = 1;
  localparam int unsigned LINE_FOOT  = 2;

endpackage

// File: rtl/strum_cmd_fifo.sv
// Command FIFO for the strum sequencer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write wdata_i (ignored when full or flushing)
//   pop_i      : drop the head entry (ignored when empty or flushing)
//   flush_i    : discard all entries
//   wdata_i    : entry to write
//   rdata_o    : head entry (show-ahead)
//   full_o     : no free entry
//   empty_o    : no stored entry
//   fill_o     : current occupancy
module strum_cmd_fifo
  import strum_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 3 + CMD_HOLD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer/occupancy stage; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage stage: data only, no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/strum_sequencer.sv
// Strum sequencer: plays queued commands as timed press/release waveforms on
// the three instrument lines (green strum, blue strum, drum foot).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cmd_valid  : command offered;  cmd_ready: command can be accepted
//   cmd_mask   : lines to press;   cmd_hold : press length in ticks (0 -> 1)
//   flush      : drop queued commands and release all lines
//   inst       : registered press lines to the debouncer
//   busy       : FSM active or commands queued
//   fill       : FIFO occupancy
module strum_sequencer
  import strum_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_TICKS  = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_mask,
  input  logic [HOLD_W-1:0]            cmd_hold,
  input  logic                         flush,
  output logic [2:0]                   inst,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fill
);

  localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DATA_W = 3 + HOLD_W;

  // A zero hold would never complete a duration compare; play it as one tick.
  function automatic logic [HOLD_W-1:0] hold_floor1(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] dur_q, dur_d;
  logic [2:0]        mask_q;
  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        inst_q, inst_d;
  logic              avail_q;
  logic              push, pop, tick, timed, entry, timer_done;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign cmd_ready = !fifo_full && !flush;
  assign push      = cmd_valid && cmd_ready;

  strum_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({cmd_mask, cmd_hold}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign timed = (state_q == S_PRESS) || (state_q == S_REST) || (state_q == S_GAP);
  assign timer_done = tick && ((state_q == S_GAP) ? (dur_q == HOLD_W'(GAP_TICKS - 1))
                                                  : (dur_q == hold_q - HOLD_W'(1)));

  // Next-state logic; flush overrides everything, but a press always ends in a gap.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = (state_q == S_PRESS) ? S_GAP : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (avail_q && !fifo_empty) state_d = S_LOAD;
        S_LOAD:  state_d = (mask_q != 3'b000) ? S_PRESS : S_REST;
        S_PRESS: if (timer_done) state_d = S_GAP;
        S_REST:  if (timer_done) state_d = S_IDLE;
        S_GAP:   if (timer_done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: lines are driven exactly while the next state is PRESS.
  always_comb begin
    pop    = (state_q == S_IDLE) && (state_d == S_LOAD);
    inst_d = (state_d == S_PRESS) ? mask_q : 3'b000;
  end

  // Tick and duration counters restart on every state entry so each timed
  // state lasts an exact multiple of TICK_DIV clocks.
  always_comb begin
    entry = flush || (state_d != state_q);
    cnt_d = '0;
    dur_d = '0;
    if (!entry) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      dur_d = (tick && timed) ? dur_q + HOLD_W'(1) : dur_q;
    end
  end

  // Control register stage. avail_q is the FIFO non-empty flag one clock
  // late, which keeps the push handshake out of the IDLE pop decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dur_q   <= '0;
      inst_q  <= 3'b000;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      inst_q  <= inst_d;
      avail_q <= !flush && !fifo_empty;
    end
  end

  // Command latch stage: data only, captured on pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      mask_q <= fifo_rdata[DATA_W-1 -: 3];
      hold_q <= hold_floor1(fifo_rdata[HOLD_W-1:0]);
    end
  end

  assign inst = inst_q;
  assign busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_strum_sequencer.sv
module tb_strum_sequencer;

  localparam int TD    = 4;
  localparam int GT    = 2;
  localparam int DEPTH = 4;
  localparam int HW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_mask;
  logic [HW-1:0] cmd_hold;
  logic          flush;
  logic [2:0]    inst;
  logic          busy;
  logic [2:0]    fill;

  int compared   = 0;
  int mismatched = 0;
  int e          = 0;

  strum_sequencer #(
    .TICK_DIV   (TD),
    .GAP_TICKS  (GT),
    .FIFO_DEPTH (DEPTH),
    .HOLD_W     (HW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mask  (cmd_mask),
    .cmd_hold  (cmd_hold),
    .flush     (flush),
    .inst      (inst),
    .busy      (busy),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: per accepted command, the edges at which it is popped,
  // its press/rest window ends, and the sequencer is idle again.
  int acc_e[$], pop_e[$], end_e[$], idle_e[$], msk[$];
  int t_idle = 0;

  task automatic model_accept(input int a, input int m, input int h);
    int he, p;
    he = (h == 0) ? 1 : h;
    p  = (a + 2 > t_idle + 1) ? a + 2 : t_idle + 1;
    acc_e.push_back(a);
    pop_e.push_back(p);
    msk.push_back(m);
    end_e.push_back(p + 1 + he * TD);
    t_idle = (m != 0) ? p + 1 + he * TD + GT * TD : p + 1 + he * TD;
    idle_e.push_back(t_idle);
  endtask

  function automatic int exp_inst(input int t);
    int r = 0;
    foreach (pop_e[k]) if (msk[k] != 0 && t >= pop_e[k] + 1 && t < end_e[k]) r = msk[k];
    return r;
  endfunction

  function automatic int exp_fill(input int t);
    int r = 0;
    foreach (acc_e[k]) begin
      if (acc_e[k] <= t) r++;
      if (pop_e[k] <= t) r--;
    end
    return r;
  endfunction

  function automatic int exp_busy(input int t);
    int r = (exp_fill(t) != 0) ? 1 : 0;
    foreach (pop_e[k]) if (t >= pop_e[k] && t < idle_e[k]) r = 1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp_v, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  int c_mask[$], c_hold[$], c_gap[$];
  int ci, gapc, nc, a;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_mask = 3'b000; cmd_hold = '0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_inst",  32'(inst), 0);
    check("reset_busy",  32'(busy), 0);
    check("reset_fill",  32'(fill), 0);
    check("reset_ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e = 0;

    // Directed entries first, then random ones.
    c_mask = '{1, 6, 1};  c_hold = '{3, 0, 50};  c_gap = '{2, 30, 30};
    for (int i = 0; i < 5; i++) begin
      c_mask.push_back($urandom_range(1, 7));
      c_hold.push_back($urandom_range(0, 3));
      c_gap.push_back(0);
    end
    c_mask.push_back(0); c_hold.push_back(2); c_gap.push_back(0);
    c_mask.push_back(4); c_hold.push_back(1); c_gap.push_back(0);
    for (int i = 0; i < 14; i++) begin
      c_mask.push_back($urandom_range(0, 7));
      c_hold.push_back($urandom_range(0, 3));
      c_gap.push_back($urandom_range(0, 25));
    end
    nc = c_mask.size();

    ci = 0;
    gapc = c_gap[0];
    for (int it = 0; it < 6000 && !(ci == nc && e >= t_idle + 2); it++) begin
      check("inst",  32'(inst), 32'(exp_inst(e)));
      check("fill",  32'(fill), 32'(exp_fill(e)));
      check("busy",  32'(busy), 32'(exp_busy(e)));
      check("ready", 32'(cmd_ready), (exp_fill(e) < DEPTH) ? 1 : 0);
      if (ci < nc && gapc == 0) begin
        cmd_valid = 1'b1;
        cmd_mask  = 3'(c_mask[ci]);
        cmd_hold  = HW'(c_hold[ci]);
        if (exp_fill(e) < DEPTH) begin
          model_accept(e + 1, c_mask[ci], c_hold[ci]);
          ci++;
          if (ci < nc) gapc = c_gap[ci];
        end
      end else begin
        cmd_valid = 1'b0;
        if (gapc > 0) gapc--;
      end
      step();
    end
    check("random_phase_done", (ci == nc && e >= t_idle + 2) ? 1 : 0, 1);
    cmd_valid = 1'b0;

    // Flush five clocks into a press with two commands queued.
    cmd_valid = 1'b1; cmd_mask = 3'b011; cmd_hold = HW'(4);
    step(); a = e;
    cmd_mask = 3'b001; cmd_hold = HW'(1);
    step();
    cmd_mask = 3'b010;
    step();
    cmd_valid = 1'b0;
    step();
    check("flush_press_on", 32'(inst), 3);
    check("flush_queued",   32'(fill), 2);
    repeat (4) step();
    check("flush_press_held", 32'(inst), 3);
    flush = 1'b1; cmd_valid = 1'b1; cmd_mask = 3'b111; cmd_hold = HW'(1);
    #1;
    check("flush_ready_low", 32'(cmd_ready), 0);
    step();
    flush = 1'b0; cmd_valid = 1'b0;
    check("flush_inst",  32'(inst), 0);
    check("flush_fill",  32'(fill), 0);
    check("flush_busy",  32'(busy), 1);
    check("flush_edge",  e - a, 8);
    repeat (7) step();
    check("flush_gap_busy", 32'(busy), 1);
    check("flush_gap_inst", 32'(inst), 0);
    step();
    check("flush_idle_busy", 32'(busy), 0);
    check("flush_idle_fill", 32'(fill), 0);
    repeat (4) step();
    check("flush_dropped_push", 32'(inst), 0);

    // Reset in the middle of a press.
    cmd_valid = 1'b1; cmd_mask = 3'b111; cmd_hold = HW'(10);
    step(); a = e;
    cmd_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_inst", 32'(inst), 7);
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    check("rst_async_inst", 32'(inst), 0);
    check("rst_async_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 1);
    check("post_rst_fill",  32'(fill), 0);
    repeat (3) step();
    check("post_rst_inst", 32'(inst), 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/strum_sequencer.md
Name: strum_sequencer

Overview:
- Command-driven sequencer that generates timed press/release waveforms on the three instrument lines (green strum, blue strum, drum foot).
- Its `inst` output feeds the instrument debouncer input `inst[2:0]`.
- Commands are accepted over a valid/ready handshake from the note-playback logic and buffered in a small FIFO.
- Each command is played as a press of programmable length followed by a fixed release gap, so every press is recognised downstream.

Parameters:
- TICK_DIV, 50000, clocks per timing tick (1 ms at 50 MHz); must be >= 2.
- GAP_TICKS, 10, release-gap length in ticks after every press; must be >= 1.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- HOLD_W, 8, width of the hold-duration field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; high when not full and flush is low.
- cmd_mask  in  3  lines to press: [0]=green strum, [1]=blue strum, [2]=drum foot.
- cmd_hold  in  HOLD_W  press duration in ticks.
- flush  in  1  synchronous abort: drop queued commands and release all lines.
- inst  out  3  registered press lines to the debouncer.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate, no clock edge needed): inst=0, state=IDLE, FIFO empty, fill=0, busy=0, cmd_ready=1, tick counter=0.
- Accept: a command is written on an edge where cmd_valid && cmd_ready.
  - Push and pop in the same cycle leave fill unchanged.
  - A push is impossible when full, because cmd_ready=0.
- Tick counter: counts 0..TICK_DIV-1 and pulses `tick` on wrap.
  - Cleared on every FSM state entry, so durations are exact multiples of TICK_DIV clocks.
- FSM states: IDLE, LOAD, PRESS, REST, GAP.
  - IDLE: if FIFO non-empty, pop the head and latch mask/hold. An effective hold of 0 is treated as 1. Go to LOAD.
  - LOAD: one cycle. If mask != 0, inst <= mask and go to PRESS. If mask == 0, inst stays 0 and go to REST.
  - PRESS: inst holds mask for exactly hold*TICK_DIV clocks. Then inst <= 0 and go to GAP.
  - REST: inst=0 for hold*TICK_DIV clocks, then go to IDLE. No gap follows a rest.
  - GAP: inst=0 for GAP_TICKS*TICK_DIV clocks, then go to IDLE.
- Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE asserts inst at edge N+3 (fill register, IDLE pop, LOAD).
- Back-to-back: inst is high for exactly hold*TICK_DIV clocks, then low for GAP_TICKS*TICK_DIV + 2 clocks (GAP plus IDLE and LOAD) before the next press.
- Flush (synchronous, priority over everything else except rst):
  - On the flush edge: FIFO cleared, fill=0, inst <= 0.
  - If the FSM was in PRESS, go to GAP (guaranteed release); otherwise go to IDLE.
  - cmd_ready=0 while flush is high; a simultaneous push is dropped.
- Duration counter: HOLD_W bits wide, compared against the latched hold, with no wrap. The maximum hold is 2^HOLD_W-1 ticks.
- inst changes only on clk edges (glitch-free, one register per line).

Decomposition:
- Package `strum_seq_pkg`: FSM state enum, command struct {mask[2:0], hold[HOLD_W-1:0]}, line-index constants (GREEN=0, BLUE=1, FOOT=2).
- Sub-module `strum_cmd_fifo`: synchronous FIFO with async reset, push/pop/flush, full/empty/fill.
- The tick counter and FSM stay in the top module.

Test Plan (TICK_DIV=4, GAP_TICKS=2, FIFO_DEPTH=4):
- Push {001, hold=3} when idle at edge N -> inst=001 from edge N+3 for 12 clocks, then 0; busy drops 8 clocks later at the return to IDLE.
- Push {110, hold=0} -> treated as hold 1: inst=110 for exactly 4 clocks, then an 8-clock gap.
- Push {001, hold=50}, then 5 more commands during the press -> fill reaches 4 and cmd_ready=0 holds the 5th. When the long press ends, the next command pops, fill becomes 3 and cmd_ready rises. Remaining presses play in order.
- Push {000, hold=2} then {100, hold=1} -> inst=0 for 8 clocks, no gap, then inst=100 two edges after REST ends.
- Flush 5 clocks into a press with 2 commands queued -> inst=0 at the next edge, fill=0, 8-clock gap, then IDLE with busy=0. A cmd_valid held during the flush is not accepted.
- Assert rst mid-press -> inst=000 and busy=0 immediately, before any clk edge. After rst deasserts, cmd_ready=1 and fill=0.
